xge_rx_frame_buffer: RTL

Store-and-forward receive buffer on the user side of the 10G MAC RX interface. It captures rx_data/rx_data_valid beats of each frame into a circular RAM. Frames that end with rx_good_frame are committed; frames that end with rx_bad_frame, or that overflow the buffer, are discarded. Committed frames are replayed on a valid/ready stream with keep and last markers, and drop statistics are counted.

---
 rtl/xge_rx_frame_buffer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/xge_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// xge_rx_frame_buffer
//
// Store-and-forward receive buffer for the user side of a 10G MAC RX port.
// Beats of each incoming frame are written tentatively into a circular RAM.
// A frame becomes visible to the reader only when it ends with rx_good_frame.
// Frames that end with rx_bad_frame, or that run out of space, are rolled back
// by rewinding the tentative write pointer. Committed frames are replayed on a
// valid/ready stream with byte keep and last markers.
//
// Ports:
//   clk, rst_n      core clock, synchronous active-low reset
//   rx_data         64-bit receive data, byte 0 in bits [7:0]
//   rx_data_valid   per-byte valid, contiguous from bit 0, nonzero = beat
//   rx_good_frame   end-of-frame pulse, good CRC
//   rx_bad_frame    end-of-frame pulse, errored frame
//   m_data/m_keep/m_last/m_valid/m_ready   output frame stream
//   good_cnt/bad_cnt/ovf_cnt               saturating frame statistics
// -----------------------------------------------------------------------------
module xge_rx_frame_buffer #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      rx_data,
  input  logic [7:0]       rx_data_valid,
  input  logic             rx_good_frame,
  input  logic             rx_bad_frame,
  output logic [63:0]      m_data,
  output logic [7:0]       m_keep,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_USED = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W:0] rd_ptr_reg, wr_commit_reg, wr_tent_reg;
  logic [ADDR_W:0] wr_commit_next, wr_tent_next;
  logic [ADDR_W:0] used;
  logic            full;

  logic beat, stat, good_pulse, bad_pulse;

  // Write-side controls produced by the FSM output process
  logic              ram_we;
  logic              last_we;
  logic              last_val;
  logic [ADDR_W-1:0] last_addr;
  logic              inc_good, inc_bad, inc_ovf;

  // Storage: data+keep in block RAM, last flags in flops so they can be set
  // at commit time independently of the data write.
  logic [71:0] mem [DEPTH];
  logic        last_mem [DEPTH];

  // Read pipeline
  logic        avail, out_en, rd_en;
  logic        s1_valid_reg;
  logic [71:0] s1_word_reg;
  logic        s1_last_reg;
  logic [63:0] m_data_reg;
  logic [7:0]  m_keep_reg;
  logic        m_last_reg;
  logic        m_valid_reg;

  assign beat       = |rx_data_valid;
  assign bad_pulse  = rx_bad_frame;                   // both together = bad
  assign good_pulse = rx_good_frame & ~rx_bad_frame;
  assign stat       = rx_good_frame | rx_bad_frame;

  assign used = wr_tent_reg - rd_ptr_reg;
  assign full = (used == FULL_USED);

  // ---------------------------------------------------------------------------
  // Write FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Write FSM: next state. A beat arriving with a status pulse is processed
  // first, so the pulse always closes the frame that includes that beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (beat) begin
          if (stat)      state_next = S_IDLE;
          else if (full) state_next = S_DROP;
          else           state_next = S_RECV;
        end
      end
      S_RECV: begin
        if (stat)              state_next = S_IDLE;
        else if (beat && full) state_next = S_DROP;
      end
      S_DROP: begin
        if (stat) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write FSM: outputs (RAM/flag writes, pointer updates, counter strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we         = 1'b0;
    last_we        = 1'b0;
    last_val       = 1'b0;
    last_addr      = wr_tent_reg[ADDR_W-1:0];
    wr_tent_next   = wr_tent_reg;
    wr_commit_next = wr_commit_reg;
    inc_good       = 1'b0;
    inc_bad        = 1'b0;
    inc_ovf        = 1'b0;
    case (state_reg)
      S_IDLE, S_RECV: begin
        if (beat && full) begin
          // Overflow: abandon the partial frame; a status pulse in the same
          // cycle already belongs to the dropped frame.
          wr_tent_next = wr_commit_reg;
          inc_ovf      = stat;
        end else begin
          if (beat) begin
            // Every write clears any stale last flag left from an older lap,
            // unless this beat is the one being committed right now.
            ram_we       = 1'b1;
            last_we      = 1'b1;
            last_val     = good_pulse;
            wr_tent_next = wr_tent_reg + PTR_ONE;
          end
          // Status in IDLE without a beat is an empty frame and is ignored.
          if (beat || (state_reg == S_RECV)) begin
            if (good_pulse) begin
              inc_good       = 1'b1;
              wr_commit_next = beat ? (wr_tent_reg + PTR_ONE) : wr_tent_reg;
              if (!beat) begin
                last_we   = 1'b1;
                last_val  = 1'b1;
                last_addr = wr_tent_reg[ADDR_W-1:0] - ADDR_ONE;
              end
            end else if (bad_pulse) begin
              inc_bad      = 1'b1;
              wr_tent_next = wr_commit_reg;
            end
          end
        end
      end
      S_DROP: inc_ovf = stat;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_tent_reg   <= '0;
      wr_commit_reg <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      wr_tent_reg   <= wr_tent_next;
      wr_commit_reg <= wr_commit_next;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters: index 0 good, 1 bad, 2 overflow
  // ---------------------------------------------------------------------------
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  assign cnt_inc = {inc_ovf, inc_bad, inc_good};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
      end
    end
  endgenerate

  assign good_cnt = cnt_reg[0];
  assign bad_cnt  = cnt_reg[1];
  assign ovf_cnt  = cnt_reg[2];

  // ---------------------------------------------------------------------------
  // Storage with registered read. A read address never collides with a write
  // address: reads stay below wr_commit, writes sit at or above it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_tent_reg[ADDR_W-1:0]] <= {rx_data_valid, rx_data};
    if (rd_en)  s1_word_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (last_we) last_mem[last_addr] <= last_val;
    if (rd_en)   s1_last_reg <= last_mem[rd_ptr_reg[ADDR_W-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: RAM read stage feeding the output register. The read stage
  // refills in the same cycle it hands off, giving one beat per cycle.
  // ---------------------------------------------------------------------------
  assign avail  = (rd_ptr_reg != wr_commit_reg);
  assign out_en = !m_valid_reg || m_ready;
  assign rd_en  = avail && (!s1_valid_reg || out_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_keep_reg   <= '0;
      m_last_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= rd_en | (s1_valid_reg & ~out_en);
      if (out_en) begin
        m_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          m_data_reg <= s1_word_reg[63:0];
          m_keep_reg <= s1_word_reg[71:64];
          m_last_reg <= s1_last_reg;
        end
      end
    end
  end

  assign m_data  = m_data_reg;
  assign m_keep  = m_keep_reg;
  assign m_last  = m_last_reg;
  assign m_valid = m_valid_reg;

endmodule
